// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side feeder: byte width and feeder FSM encoding.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Circular byte buffer with registered count/full/empty, synchronous clear and overflow pulse.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [UART_DATA_W-1:0] push_data,
  input  logic                   pop,
  input  logic                   clear,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [AW:0]            count,
  output logic                   overflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [UART_DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            count_nxt;
  logic                   push_ok;
  logic                   pop_ok;

  // full is the registered flag, so a pop in the same cycle does not make room for a push
  assign push_ok = push && !full && !clear;
  assign pop_ok  = pop && !empty && !clear;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok)      count_nxt = count + (AW+1)'(1);
    else if (pop_ok && !push_ok) count_nxt = count - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_nxt;
      full     <= (count_nxt == FULL_CNT);
      empty    <= (count_nxt == '0);
      overflow <= push && full;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Feeds queued bytes to a UART transmitter one frame at a time, paced by its busy/done handshake.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [UART_DATA_W-1:0] push_data,
  input  logic                   clear,
  output logic                   full,
  output logic                   empty,
  output logic [AW:0]            count,
  output logic                   overflow,
  output logic                   tx_start,
  output logic [UART_DATA_W-1:0] tx_din,
  input  logic                   tx_busy,
  input  logic                   tx_done
);

  feeder_state_t          state_q;
  feeder_state_t          state_d;
  logic                   launch;
  logic [UART_DATA_W-1:0] rd_data;

  byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (launch),
    .clear     (clear),
    .rd_data   (rd_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow)
  );

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !tx_busy && !clear) begin
          launch  = 1'b1;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        // A stray done here means the frame already finished; do not wait for busy.
        if (tx_done)      state_d = IDLE;
        else if (tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      tx_start <= 1'b0;
      tx_din   <= '0;
    end else begin
      state_q  <= state_d;
      tx_start <= launch;
      if (launch) tx_din <= rd_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder (DEPTH=4) driving a small behavioural UART transmitter.
module tb_uart_tx_feeder;
  import uart_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int BT    = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       push = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic       clear = 1'b0;
  logic       full, empty, overflow, tx_start;
  logic [AW:0] count;
  logic [7:0] tx_din;
  logic       tx_busy, tx_done;
  logic       hold_busy = 1'b0;
  logic       mon_clr = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_tx_feeder #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .push      (push),
    .push_data (push_data),
    .clear     (clear),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .tx_start  (tx_start),
    .tx_din    (tx_din),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  // Behavioural transmitter: 10-bit frame, BT clocks per bit
  logic       m_busy, txd;
  logic [9:0] frame;
  int         bitn, tick;
  assign tx_busy = m_busy | hold_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; tx_done <= 1'b0; txd <= 1'b1;
      frame <= '0; bitn <= 0; tick <= 0;
    end else begin
      tx_done <= 1'b0;
      if (!m_busy) begin
        if (tx_start) begin
          frame <= {1'b1, tx_din, 1'b0};
          m_busy <= 1'b1; bitn <= 0; tick <= 0; txd <= 1'b0;
        end
      end else if (tick == BT-1) begin
        tick <= 0;
        if (bitn == 9) begin
          m_busy <= 1'b0; tx_done <= 1'b1; txd <= 1'b1;
        end else begin
          bitn <= bitn + 1;
          txd  <= frame[bitn+1];
        end
      end else begin
        tick <= tick + 1;
      end
    end
  end

  // Monitor: launch log, protocol violations, overflow pulses, peak count
  logic [7:0] log_q [64];
  int         log_n = 0;
  int         viol = 0;
  int         ovf_n = 0;
  int         max_cnt = 0;
  logic       prev_start = 1'b0;

  always @(posedge clk) begin
    prev_start <= tx_start;
    if (tx_start) begin
      log_q[log_n] <= tx_din;
      log_n <= log_n + 1;
      if (tx_busy || prev_start || tx_done) viol <= viol + 1;
    end
    if (overflow) ovf_n <= ovf_n + 1;
    if (mon_clr) max_cnt <= 0;
    else if (int'(count) > max_cnt) max_cnt <= int'(count);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_seq(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      push = 1'b1; push_data = first + 8'(i);
      @(negedge clk);
    end
    push = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int target);
    int k;
    k = 0;
    while (!(log_n >= target && dut.state_q == IDLE && !tx_busy && empty) && k < 2000) begin
      @(negedge clk); k++;
    end
    check({tag, "_drain_timeout"}, (k < 2000), 1);
    repeat (40) @(negedge clk);
    check({tag, "_launches"}, log_n, target);
  endtask

  logic [9:0] line_bits;
  int base, k;

  initial begin
    repeat (3) @(negedge clk);
    // reset state
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_din", tx_din, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // single byte A5
    push = 1'b1; push_data = 8'hA5;
    @(negedge clk); push = 1'b0;
    check("single_empty_E0", empty, 0);
    check("single_count_E0", count, 1);
    check("single_start_E0", tx_start, 0);
    @(negedge clk);
    check("single_start_E1", tx_start, 1);
    check("single_din_E1", tx_din, 8'hA5);
    check("single_count_E1", count, 0);
    check("single_empty_E1", empty, 1);
    @(negedge clk);
    check("single_start_E2", tx_start, 0);
    check("single_busy_E2", tx_busy, 1);
    line_bits = '0;
    for (int b = 0; b < 10; b++) begin
      line_bits = {line_bits[8:0], txd};
      repeat (BT) @(negedge clk);
    end
    check("single_serial", line_bits, 10'b0101001011);
    k = 0;
    while (dut.state_q != IDLE && k < 100) begin @(negedge clk); k++; end
    check("single_idle", dut.state_q, IDLE);
    check("single_empty_end", empty, 1);
    check("single_launches", log_n, 1);

    // burst 01..04
    mon_clr = 1'b1; @(negedge clk); mon_clr = 1'b0;
    base = log_n;
    push_seq(8'h01, 4);
    wait_drain("burst", base + 4);
    check("burst_peak", max_cnt, 3);
    for (int i = 0; i < 4; i++) check("burst_order", log_q[base+i], 8'h01 + 8'(i));

    // full / overflow
    base = log_n;
    k = ovf_n;
    hold_busy = 1'b1; @(negedge clk);
    push_seq(8'h20, 3);
    check("full_before4", full, 0);
    push = 1'b1; push_data = 8'h23; @(negedge clk);
    check("full_after4", full, 1);
    check("full_count", count, 4);
    push_data = 8'h24; @(negedge clk);
    push_data = 8'h25; @(negedge clk);
    push = 1'b0;
    @(negedge clk);
    check("ovf_pulses", ovf_n - k, 2);
    check("ovf_low", overflow, 0);
    hold_busy = 1'b0;
    wait_drain("full", base + 4);
    for (int i = 0; i < 4; i++) check("full_order", log_q[base+i], 8'h20 + 8'(i));

    // wrap-around, groups of 3
    mon_clr = 1'b1; @(negedge clk); mon_clr = 1'b0;
    base = log_n;
    for (int g = 0; g < 4; g++) begin
      push_seq(8'h10 + 8'(3*g), (g == 3) ? 1 : 3);
      wait_drain("wrap", base + ((g == 3) ? 10 : 3*(g+1)));
    end
    for (int i = 0; i < 10; i++) check("wrap_order", log_q[base+i], 8'h10 + 8'(i));
    check("wrap_peak_le4", (max_cnt <= 4), 1);

    // clear during first frame
    base = log_n;
    push_seq(8'h30, 3);
    k = 0;
    while (!tx_busy && k < 20) begin @(negedge clk); k++; end
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    check("clear_count", count, 0);
    check("clear_empty", empty, 1);
    check("clear_inflight_busy", tx_busy, 1);
    k = 0;
    while (!tx_done && k < 100) begin @(negedge clk); k++; end
    check("clear_done_seen", tx_done, 1);
    repeat (40) @(negedge clk);
    check("clear_launches", log_n, base + 1);
    check("clear_byte", log_q[base], 8'h30);

    // reset mid-frame
    base = log_n;
    push_seq(8'h40, 3);
    k = 0;
    while (dut.state_q != WAIT_DONE && k < 20) begin @(negedge clk); k++; end
    check("rstm_queued", count, 2);
    rst_n = 1'b0; #1;
    check("rstm_count", count, 0);
    check("rstm_empty", empty, 1);
    check("rstm_full", full, 0);
    check("rstm_tx_start", tx_start, 0);
    check("rstm_tx_din", tx_din, 8'h00);
    check("rstm_state", dut.state_q, IDLE);
    @(negedge clk); rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rstm_no_launch", log_n, base + 1);
    check("rstm_still_empty", empty, 1);

    check("protocol_violations", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
